adder_sched: RTL and testbench

ADDER_SCHED -- requirements
Module: adder_sched

---
 rtl/adder_sched_pkg.sv | 28 ++
 rtl/adder_sched_arb.sv | 38 +++
 rtl/adder_sched.sv | 112 +++++++++++
 tb/tb_adder_sched.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_sched_pkg.sv
// Shared types and constants for the adder scheduler: FSM states, operand/result
// widths and bit positions of the fields in the external adder's result word.
package adder_sched_pkg;

  localparam int OPW  = 4;
  localparam int RESW = 5;
  localparam int IDW  = 3;
  localparam int VALW = 10;

  localparam int VAL_COUT1    = 9;
  localparam int VAL_COUT0    = 8;
  localparam int VAL_SUM0_LSB = 4;
  localparam int VAL_SUM1_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RESP
  } state_t;

  // The adder computes both carry-in cases at once; keep the one we asked for.
  function automatic logic [RESW-1:0] pick_result(input logic [VALW-1:0] value,
                                                  input logic            cin);
    return cin ? {value[VAL_COUT1], value[VAL_SUM1_LSB +: OPW]}
               : {value[VAL_COUT0], value[VAL_SUM0_LSB +: OPW]};
  endfunction

endpackage

// File: rtl/adder_sched_arb.sv
// Round-robin arbiter: one-hot grant, searching upward from last_grant+1 with wrap.
module rr_arbiter
  import adder_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic            en,
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  int              start;
  int              pos;
  int              sel;
  logic [NREQ-1:0] rot;

  // Rotate so bit 0 is the highest-priority requester, then take the lowest set bit.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    grant     = '0;
    grant_idx = '0;
    pos       = 0;
    sel       = 0;
    start     = (int'(last_grant) + 1) % NREQ;
    rot       = NREQ'({req, req} >> start);
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) pos = i;
    end
    if (en && (rot != '0)) begin
      sel       = (start + pos) % NREQ;
      grant     = NREQ'(1) << sel;
      grant_idx = IDW'(sel);
    end
  end

endmodule

// File: rtl/adder_sched.sv
// Schedules NREQ requesters onto one registered external 4-bit adder.
// Optional completed-operation counter enabled by defining ADDER_SCHED_STATS_EN.
module adder_sched
  import adder_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [OPW*NREQ-1:0]  req_a,
  input  logic [OPW*NREQ-1:0]  req_b,
  input  logic [NREQ-1:0]      req_cin,
  output logic [OPW-1:0]       reg_0,
  output logic [OPW-1:0]       reg_1,
  input  logic                 guard,
  input  logic [VALW-1:0]      value,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [RESW-1:0]      rsp_sum,
  output logic [15:0]          stat_ops
);

  state_t          state, state_nxt;
  logic [IDW-1:0]  last_grant;
  logic [IDW-1:0]  grant_idx;
  logic [NREQ-1:0] grant;
  logic            accept;
  logic            cin_q;
  logic [OPW-1:0]  a_sel, b_sel;
  logic            cin_sel;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .en         (state == ST_IDLE),
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |(req_valid & grant);
  assign rsp_valid = (state == ST_RESP);

  always_comb begin
    a_sel   = '0;
    b_sel   = '0;
    cin_sel = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        a_sel   = req_a[i*OPW +: OPW];
        b_sel   = req_b[i*OPW +: OPW];
        cin_sel = req_cin[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (accept)    state_nxt = ST_ISSUE;
      ST_ISSUE: if (guard)     state_nxt = ST_RESP;
      ST_RESP:  if (rsp_ready) state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  // Reset anywhere drops an in-flight operation; its response is never presented.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples values from before the edge.
    if (rst_n) begin
      state      <= ST_IDLE;
      last_grant <= IDW'(NREQ - 1);
      reg_0      <= '0;
      reg_1      <= '0;
      cin_q      <= 1'b0;
      rsp_id     <= '0;
      rsp_sum    <= '0;
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) && accept) begin
        reg_0      <= a_sel;
        reg_1      <= b_sel;
        cin_q      <= cin_sel;
        rsp_id     <= grant_idx;
        last_grant <= grant_idx;
      end
      if ((state == ST_ISSUE) && guard) begin
        rsp_sum <= pick_result(value, cin_q);
      end
    end
  end

`ifdef ADDER_SCHED_STATS_EN
  logic [15:0] ops_cnt;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      ops_cnt <= '0;
    end else if (rsp_valid && rsp_ready && (ops_cnt != 16'hFFFF)) begin
      ops_cnt <= ops_cnt + 16'd1;
    end
  end

  assign stat_ops = ops_cnt;
`else
  assign stat_ops = '0;
`endif

endmodule

// File: tb/tb_adder_sched.sv
// Scoreboard bench for adder_sched: directed requests push expected {id,sum};
// a negedge monitor pops and compares on every response handshake.
module tb_adder_sched;
  import adder_sched_pkg::*;

  localparam int NREQ = 4;
`ifdef ADDER_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic [IDW-1:0]  id;
    logic [RESW-1:0] sum;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [OPW*NREQ-1:0] req_a, req_b;
  logic [NREQ-1:0]     req_cin;
  logic [OPW-1:0]      reg_0, reg_1;
  logic                guard;
  logic [VALW-1:0]     value;
  logic                rsp_valid, rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [RESW-1:0]     rsp_sum;
  logic [15:0]         stat_ops;

  logic [OPW-1:0] a_arr [NREQ];
  logic [OPW-1:0] b_arr [NREQ];
  logic [4:0]     s0, s1;
  logic [3:0]     gexp [5];

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp   = 0;
  int   n_err   = 0;
  int   exp_ops = 0;

  always #5 clk = ~clk;

  adder_sched #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .reg_0     (reg_0),
    .reg_1     (reg_1),
    .guard     (guard),
    .value     (value),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .stat_ops  (stat_ops)
  );

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*OPW +: OPW] = a_arr[i];
      req_b[i*OPW +: OPW] = b_arr[i];
    end
  end

  // External adder model: both carry-in results from the registered operands.
  assign s0    = {1'b0, reg_0} + {1'b0, reg_1};
  assign s1    = s0 + 5'd1;
  assign value = {s1[4], s0[4], s0[3:0], s1[3:0]};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: no DUT event within cycle budget (t=%0t)", name, $time);
  endtask

  task automatic push(input logic [IDW-1:0] id, input logic [RESW-1:0] sum);
    exp_t e;
    e.id  = id;
    e.sum = sum;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [1:0] idx, input logic [3:0] a, input logic [3:0] b,
                       input logic cin);
    a_arr[idx]     = a;
    b_arr[idx]     = b;
    req_cin[idx]   = cin;
    req_valid[idx] = 1'b1;
  endtask

  task automatic wait_accept(input logic [1:0] idx);
    int n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (req_ready[idx]) break;
      n++;
    end
    if (n >= 40) timeout("accept_wait");
    else begin
      @(posedge clk); #1;
      req_valid[idx] = 1'b0;
    end
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (rsp_valid) break;
      n++;
    end
    if (n >= 40) timeout("rsp_wait");
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0) && (n < 60)) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) timeout("drain");
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rsp: id %0d sum %0d, expected no response", rsp_id, rsp_sum);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(mon_e.id));
        check("rsp_sum", 32'(rsp_sum), 32'(mon_e.sum));
        exp_ops++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ng;
    int last_c;
    rst_n     = 1'b1;
    req_valid = '0;
    req_cin   = '0;
    rsp_ready = 1'b1;
    guard     = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = '0;
      b_arr[i] = '0;
    end
    gexp = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_sum", 32'(rsp_sum), 32'd0);
    check("rst_reg_0", 32'(reg_0), 32'd0);
    check("rst_reg_1", 32'(reg_1), 32'd0);
    check("rst_stat_ops", 32'(stat_ops), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;

    // 7+9, cin=0 -> 16 on requester 0; response visible two edges after accept
    issue(2'd0, 4'd7, 4'd9, 1'b0);
    push(3'd0, 5'd16);
    wait_accept(2'd0);
    @(negedge clk);
    check("lat_t1_rsp_valid", 32'(rsp_valid), 32'd0);
    check("issue_reg_0", 32'(reg_0), 32'd7);
    check("issue_reg_1", 32'(reg_1), 32'd9);
    @(negedge clk);
    check("lat_t2_rsp_valid", 32'(rsp_valid), 32'd1);
    drain();

    // 15+15+1 -> 31 on requester 2
    issue(2'd2, 4'd15, 4'd15, 1'b1);
    push(3'd2, 5'd31);
    wait_accept(2'd2);
    drain();

    // All four requesting from reset: order 0,1,2,3,0 at 3-cycle spacing
    rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n   = 1'b0;
    exp_ops = 0;
    a_arr[0] = 4'd1;  b_arr[0] = 4'd2; req_cin[0] = 1'b0;
    a_arr[1] = 4'd3;  b_arr[1] = 4'd4; req_cin[1] = 1'b1;
    a_arr[2] = 4'd8;  b_arr[2] = 4'd8; req_cin[2] = 1'b0;
    a_arr[3] = 4'd15; b_arr[3] = 4'd1; req_cin[3] = 1'b1;
    push(3'd0, 5'd3);
    push(3'd1, 5'd8);
    push(3'd2, 5'd16);
    push(3'd3, 5'd17);
    push(3'd0, 5'd3);
    req_valid = 4'hF;
    ng     = 0;
    last_c = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        check("grant_order", 32'(req_ready), 32'(gexp[ng]));
        if (ng > 0) check("grant_spacing", 32'(c - last_c), 32'd3);
        last_c = c;
        ng++;
        if (ng == 5) break;
      end
    end
    if (ng < 5) timeout("grant_sequence");
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    // Response back-pressure: outputs hold, no new grant while stalled
    rsp_ready = 1'b0;
    issue(2'd1, 4'd5, 4'd6, 1'b1);
    push(3'd1, 5'd12);
    wait_accept(2'd1);
    issue(2'd3, 4'd9, 4'd4, 1'b0);
    push(3'd3, 5'd13);
    wait_rsp();
    for (int k = 0; k < 5; k++) begin
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall_rsp_id", 32'(rsp_id), 32'd1);
      check("stall_rsp_sum", 32'(rsp_sum), 32'd12);
      check("stall_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_accept(2'd3);
    drain();

    // Adder not ready for 3 cycles: operands held, response one edge after guard
    guard = 1'b0;
    issue(2'd0, 4'd10, 4'd3, 1'b1);
    push(3'd0, 5'd14);
    wait_accept(2'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("guard_hold_reg_0", 32'(reg_0), 32'd10);
      check("guard_hold_reg_1", 32'(reg_1), 32'd3);
      check("guard_rsp_valid_low", 32'(rsp_valid), 32'd0);
    end
    guard = 1'b1;
    @(negedge clk);
    check("lat_t5_rsp_valid", 32'(rsp_valid), 32'd1);
    drain();

    // Reset while a response is pending: it is dropped and arbitration restarts
    check("stat_ops_pre_reset", 32'(stat_ops), STATS ? 32'(exp_ops) : 32'd0);
    rsp_ready = 1'b0;
    issue(2'd1, 4'd2, 4'd2, 1'b0);
    wait_accept(2'd1);
    wait_rsp();
    rst_n   = 1'b1;
    exp_ops = 0;
    @(negedge clk);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_rsp_sum", 32'(rsp_sum), 32'd0);
    check("abort_stat_ops", 32'(stat_ops), 32'd0);
    @(posedge clk); #1;
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    issue(2'd2, 4'd6, 4'd7, 1'b1);
    issue(2'd0, 4'd4, 4'd4, 1'b0);
    push(3'd0, 5'd8);
    push(3'd2, 5'd14);
    @(negedge clk);
    check("post_reset_grant", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_accept(2'd2);
    drain();

    check("sb_empty", 32'(sb.size()), 32'd0);
    check("stat_ops_final", 32'(stat_ops), STATS ? 32'(exp_ops) : 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
